prog_mem_loader: RTL

- Program-memory responder on the slave side of mem_bus. The CPU drives the fetch address; this block returns the instruction byte.
- Holds a 16 x 8 instruction store.
- A byte-stream loader fills the store from a host source, such as a UART receiver, through a valid/ready handshake.
- While a load is in progress, the block asserts cpu_hold so that the CPU is kept in reset.

---
 rtl/prog_mem_loader_if.sv | 12 +
 rtl/prog_mem_loader.sv | 80 ++++++++
 2 files changed

// File: rtl/prog_mem_loader_if.sv
// CPU-side program memory bus: the CPU drives the fetch address and the responder returns the instruction word.
// Purely combinational wires, with no handshake on this bus.
interface mem_bus_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic [AW-1:0] addr;
   logic [DW-1:0] data;

   modport slave  (input addr, output data);
   modport master (output addr, input data);
endinterface

// File: rtl/prog_mem_loader.sv
// Program store with a byte-stream loader. Reads are zero-latency and writes land on the next edge.
// ld_ready is high for the whole of LOAD, so the host stalls itself by dropping ld_valid, and the CPU is held in reset meanwhile.
module prog_mem_loader #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_bus_if.slave      mem_bus,
   input  logic          load_start,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_valid,
   output logic          ld_ready,
   output logic          cpu_hold,
   output logic          load_done,
   output logic [DW-1:0] checksum,
   output logic [AW-1:0] wptr
);

   if (DEPTH != (1 << AW)) begin : g_depth_check
      $error("prog_mem_loader: DEPTH must equal 2**AW");
   end

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t        state, state_d;
   logic [DW-1:0] store [DEPTH];
   logic          xfer;
   logic          last;

   // A restart in the same cycle as an offered byte takes priority, so that byte is dropped.
   assign xfer = (state == LOAD) && ld_valid && !load_start;
   assign last = (wptr == AW'(DEPTH - 1));

   assign mem_bus.data = store[mem_bus.addr];

   always_comb begin
      state_d   = state;
      ld_ready  = 1'b0;
      cpu_hold  = 1'b0;
      load_done = 1'b0;
      case (state)
         IDLE: begin
            if (load_start) state_d = LOAD;
         end
         LOAD: begin
            ld_ready = 1'b1;
            cpu_hold = 1'b1;
            if (xfer && last) state_d = DONE;
         end
         DONE: begin
            load_done = 1'b1;
            cpu_hold  = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         wptr     <= '0;
         checksum <= '0;
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else begin
         state <= state_d;
         if (load_start && (state != DONE)) begin
            wptr     <= '0;
            checksum <= '0;
         end else if (xfer) begin
            store[wptr] <= ld_data;
            checksum    <= checksum + ld_data;
            wptr        <= wptr + 1'b1;
         end
      end
   end

endmodule
